// File: rtl/tiny_nn_stream_arb.sv
// tiny_nn_stream_arb
// Owns the 16-bit data_i bus of tiny_nn_top. Whole command frames from
// NumReq requesters are granted round-robin at frame boundaries, streamed
// contiguously, closed with FPStdNaN and followed by DrainCycles idle words
// so the core returns to NNIdle and flushes its results. The core's output
// bytes are passed back tagged with the ID of the frame that produced them.
//
// Ports:
//   clk_i, rst_ni   clock, asynchronous active-low reset
//   req_valid_i     per-requester word valid
//   req_data_i      per-requester word, slice i is [16*i+:16]
//   req_last_i      final operand word of the frame
//   req_ready_o     word accepted this cycle
//   nn_data_o       registered word to tiny_nn_top data_i
//   nn_data_i       tiny_nn_top data_o
//   rsp_valid_o     rsp_data_o belongs to a frame window
//   rsp_data_o      nn_data_i, combinational pass-through
//   rsp_id_o        owner of the rsp_data_o byte
//   busy_o          controller not idle
//   err_o           sticky underflow flag
//   err_clr_i       clears err_o (a simultaneous underflow wins)
//
// state   | meaning
// --------+--------------------------------------------------------------
// StIdle  | no frame; arbitrate among valid requesters, register owner
// StStream| pass owner's words through; valid drop = underflow abort
// StTerm  | load FPStdNaN terminator for one cycle
// StDrain | load IdleWord while the drain counter runs down to 0
module tiny_nn_stream_arb #(
  parameter int unsigned NumReq      = 2,
  parameter int unsigned IdW         = (NumReq > 2) ? $clog2(NumReq) : 1,
  parameter int unsigned DrainCycles = 6,
  parameter logic [15:0] IdleWord    = 16'h0000,
  parameter logic [15:0] FPStdNaN    = 16'h7E00
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic [NumReq-1:0]      req_valid_i,
  input  logic [NumReq*16-1:0]   req_data_i,
  input  logic [NumReq-1:0]      req_last_i,
  output logic [NumReq-1:0]      req_ready_o,
  output logic [15:0]            nn_data_o,
  input  logic [7:0]             nn_data_i,
  output logic                   rsp_valid_o,
  output logic [7:0]             rsp_data_o,
  output logic [IdW-1:0]         rsp_id_o,
  output logic                   busy_o,
  output logic                   err_o,
  input  logic                   err_clr_i
);

  localparam int unsigned CntW = (DrainCycles > 1) ? $clog2(DrainCycles) : 1;

  typedef enum logic [1:0] {
    StIdle,
    StStream,
    StTerm,
    StDrain
  } state_e;

  state_e          state_q, state_d;
  logic [IdW-1:0]  owner_q, owner_d;
  logic [IdW-1:0]  ptr_q, ptr_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [15:0]     nn_data_q, nn_data_d;
  logic            err_q, err_d;

  // win0/id0 describe the word currently on nn_data_o; the two following
  // stages match the core's input and output registers.
  logic            win_d, win0_q, win1_q, win2_q;
  logic [IdW-1:0]  id0_q, id1_q, id2_q;

  logic            gnt_found;
  logic [IdW-1:0]  gnt_idx;
  logic [IdW:0]    arb_sum;

  logic [15:0]     req_word [NumReq];

  for (genvar g = 0; g < NumReq; g++) begin : g_split
    assign req_word[g] = req_data_i[16*g +: 16];
  end

  function automatic logic [IdW-1:0] wrap_inc(input logic [IdW-1:0] v);
    logic [IdW:0] s;
    s = {1'b0, v} + 1'b1;
    if (s >= (IdW+1)'(NumReq)) s = '0;
    return s[IdW-1:0];
  endfunction

  // First valid requester at or after the pointer, wrapping.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    arb_sum   = '0;
    for (int k = 0; k < NumReq; k++) begin
      arb_sum = {1'b0, ptr_q} + (IdW+1)'(k);
      if (arb_sum >= (IdW+1)'(NumReq)) arb_sum = arb_sum - (IdW+1)'(NumReq);
      if (!gnt_found && req_valid_i[arb_sum[IdW-1:0]]) begin
        gnt_found = 1'b1;
        gnt_idx   = arb_sum[IdW-1:0];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    ptr_d       = ptr_q;
    cnt_d       = cnt_q;
    nn_data_d   = IdleWord;
    win_d       = 1'b0;
    err_d       = err_clr_i ? 1'b0 : err_q;
    req_ready_o = '0;

    unique case (state_q)
      StIdle: begin
        if (gnt_found) begin
          owner_d = gnt_idx;
          ptr_d   = wrap_inc(gnt_idx);
          state_d = StStream;
        end
      end
      StStream: begin
        win_d = 1'b1;
        if (req_valid_i[owner_q]) begin
          req_ready_o[owner_q] = 1'b1;
          nn_data_d            = req_word[owner_q];
          if (req_last_i[owner_q]) state_d = StTerm;
        end else begin
          // Underflow: abort the frame; set beats a same-cycle clear.
          err_d   = 1'b1;
          state_d = StTerm;
        end
      end
      StTerm: begin
        win_d     = 1'b1;
        nn_data_d = FPStdNaN;
        cnt_d     = CntW'(DrainCycles - 1);
        state_d   = StDrain;
      end
      StDrain: begin
        win_d = 1'b1;
        if (cnt_q == '0) state_d = StIdle;
        else             cnt_d   = cnt_q - 1'b1;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= StIdle;
      owner_q   <= '0;
      ptr_q     <= '0;
      cnt_q     <= '0;
      nn_data_q <= IdleWord;
      err_q     <= 1'b0;
      win0_q    <= 1'b0;
      win1_q    <= 1'b0;
      win2_q    <= 1'b0;
      id0_q     <= '0;
      id1_q     <= '0;
      id2_q     <= '0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
      nn_data_q <= nn_data_d;
      err_q     <= err_d;
      win0_q    <= win_d;
      win1_q    <= win0_q;
      win2_q    <= win1_q;
      id0_q     <= owner_q;
      id1_q     <= id0_q;
      id2_q     <= id1_q;
    end
  end

  assign nn_data_o   = nn_data_q;
  assign rsp_valid_o = win2_q;
  assign rsp_id_o    = id2_q;
  assign rsp_data_o  = nn_data_i;
  assign busy_o      = (state_q != StIdle);
  assign err_o       = err_q;

endmodule

// File: doc/tiny_nn_stream_arb.md
Name: tiny_nn_stream_arb

Overview:
- Sits in front of tiny_nn_top and owns its 16-bit data_i bus, which consumes one word every cycle.
- Arbitrates whole command frames from NumReq requesters with round-robin priority at frame boundaries. Streams each frame contiguously, appends the FPStdNaN terminator, then drives idle words for a fixed drain period.
- Returns the tiny_nn_top output bytes for the frame's window, tagged with the owner's ID.

Parameters:
- NumReq, 2, number of requesters (2..4).
- IdW, 1, width of the requester ID, $clog2(NumReq) (minimum 1).
- DrainCycles, 6, idle words driven after the terminator so the core returns to NNIdle and results flush.
- IdleWord, 16'h0000, word driven when no frame is active; its [15:12] is not a command opcode.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset, asynchronous, active-low
- req_valid_i  in  NumReq  per-requester word valid
- req_data_i  in  NumReq*16  per-requester word; slice i is [16*i+:16]
- req_last_i  in  NumReq  marks the final operand word of the frame
- req_ready_o  out  NumReq  word accepted this cycle
- nn_data_o  out  16  registered word to tiny_nn_top data_i
- nn_data_i  in  8  tiny_nn_top data_o
- rsp_valid_o  out  1  rsp_data_o belongs to the current or previous frame window
- rsp_data_o  out  8  nn_data_i passed through combinationally
- rsp_id_o  out  IdW  owner of the rsp_data_o byte
- busy_o  out  1  state is not Idle
- err_o  out  1  sticky underflow error
- err_clr_i  in  1  clears err_o

Behaviour:
- Reset values: nn_data_o=IdleWord, req_ready_o=0, rsp_valid_o=0, rsp_id_o=0, busy_o=0, err_o=0. Round-robin pointer=0, state Idle.
- States and transitions:
  - Idle -> Stream when any req_valid_i is set.
  - Stream -> Term on an accepted word with req_last_i=1.
  - Stream -> Term on underflow.
  - Term -> Drain after one cycle.
  - Drain -> Idle when the drain counter reaches 0.
- Idle:
  - Grant goes to the first valid requester at or after the pointer, wrapping.
  - The grant is registered as owner. The pointer becomes owner+1 mod NumReq.
- A single-cycle frame from Idle is legal: command word with req_last_i=1 goes Idle -> Stream -> Term.
- Stream:
  - req_ready_o[owner] = req_valid_i[owner]. All other ready bits are 0.
  - Each accepted word is registered to nn_data_o on the next edge. The first word of a frame is the command word.
  - Data on req_data_i is accepted only when valid and ready are both high.
- Underflow:
  - Condition: req_valid_i[owner]=0 during Stream.
  - Response: set err_o and go to Term (abort). No ready is asserted that cycle.
  - The remainder of that requester's frame is not dropped automatically; the requester must restart.
- Term: nn_data_o=FPStdNaN for exactly 1 cycle. No readies are asserted.
- Drain:
  - nn_data_o=IdleWord for DrainCycles cycles, counted DrainCycles-1 down to 0.
  - No readies are asserted.
  - The next arbitration happens in Idle, so back-to-back frames have at least 1 Idle-word cycle between them.
- Response timing:
  - Word at nn_data_o in cycle t produces nn_data_i in cycle t+2 (input register plus output register in the core).
  - A 2-stage shift of {window, owner} tracks this. window=1 for every cycle nn_data_o carries a frame, Term or Drain word.
  - rsp_valid_o and rsp_id_o are the stage-2 values.
- err_o:
  - Set by underflow. Cleared by err_clr_i.
  - If set and clear occur in the same cycle, set wins.
- Reset mid-frame: everything returns to reset values immediately; the in-flight frame is lost. On the first cycle after reset release nn_data_o=IdleWord.
- Simultaneous requests: only one grant per Idle cycle. Losers wait with valid held, and get no ready until granted.

Test Plan:
- Reset: hold rst_ni=0 for 3 cycles, then release -> nn_data_o=16'h0000, all readies 0, rsp_valid_o=0, err_o=0.
- Single frame: req0 sends {command word, 3 operand words}, last on word 4 -> nn_data_o carries those words, then FPStdNaN, then 6×16'h0000. rsp_valid_o is high for 11 cycles starting 2 cycles after the command word. rsp_id_o=0.
- Round-robin: req0 and req1 both valid from reset, each with 2-word frames -> order req0, req1, req0. Each req1 byte has rsp_id_o=1.
- Underflow: req1 drops valid after 1 operand word -> err_o=1, FPStdNaN on the next cycle, then drain. err_clr_i=1 clears err_o; err_clr_i=1 coinciding with a new underflow leaves err_o=1.
- Single-cycle frame: command word with last=1 -> exactly 1 frame word then FPStdNaN; ready is high for exactly 1 cycle.
- Mid-frame reset: assert rst_ni low during Stream -> nn_data_o=16'h0000 and busy_o=0 immediately; after release, arbitration restarts at req0.
